// File: rtl/axi_master_arbiter_pkg.sv
// Shared types and constants for the axi_master round-robin arbiter.
// Holds the FSM encoding, the accept-handshake timeout and a small wrap helper.
package axi_master_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_ACCEPT = 2'd2,
        S_BUSY   = 2'd3
    } state_t;

    // Cycles the master may keep o_ready high after a start strobe before we give up.
    localparam int ACCEPT_TIMEOUT = 4;
    localparam int ACCEPT_CNT_W   = $clog2(ACCEPT_TIMEOUT);

    function automatic int wrap_inc(input int value, input int modulus);
        return (value + 1 >= modulus) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: picks the first requester at or after ptr.
// Produces a one-hot grant and its index; both are zero when nothing requests.
module rr_arbiter #(
    parameter  int NUM_PORTS = 4,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     index
);

    logic found;
    int   pos;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NUM_PORTS) pos = pos - NUM_PORTS;
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                index      = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/axi_master_arbiter.sv
// Round-robin front end that shares one axi_master user interface between NUM_PORTS
// requesters, one transaction at a time, steering write/read streams to the granted port.
module axi_master_arbiter
    import axi_master_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 4
) (
    input  logic                             i_axi_clk,
    input  logic                             i_axi_rst,
    input  logic [NUM_PORTS-1:0]             i_req_valid,
    input  logic [NUM_PORTS-1:0]             i_req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  i_req_addr,
    input  logic [NUM_PORTS*8-1:0]           i_req_len,
    output logic [NUM_PORTS-1:0]             o_req_grant,
    output logic [NUM_PORTS-1:0]             o_req_done,
    output logic                             o_id_err,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  i_usr_w_tdata,
    input  logic [NUM_PORTS*STRB_WIDTH-1:0]  i_usr_w_tstrb,
    input  logic [NUM_PORTS-1:0]             i_usr_w_tlast,
    input  logic [NUM_PORTS-1:0]             i_usr_w_tvalid,
    output logic [NUM_PORTS-1:0]             o_usr_w_tready,
    output logic [DATA_WIDTH-1:0]            o_usr_r_tdata,
    output logic                             o_usr_r_tlast,
    output logic [NUM_PORTS-1:0]             o_usr_r_tvalid,
    input  logic [NUM_PORTS-1:0]             i_usr_r_tready,
    input  logic                             m_ready,
    input  logic [ID_WIDTH-1:0]              m_resp_id,
    output logic                             m_start_read_stb,
    output logic                             m_start_write_stb,
    output logic [ID_WIDTH-1:0]              m_id,
    output logic [ADDR_WIDTH-1:0]            m_addr,
    output logic [7:0]                       m_data_len,
    output logic [DATA_WIDTH-1:0]            m_w_tdata,
    output logic [STRB_WIDTH-1:0]            m_w_tstrb,
    output logic                             m_w_tlast,
    output logic                             m_w_tvalid,
    input  logic                             m_w_tready,
    input  logic [DATA_WIDTH-1:0]            m_r_tdata,
    input  logic                             m_r_tlast,
    input  logic                             m_r_tvalid,
    output logic                             m_r_tready
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_ports
        $error("axi_master_arbiter: NUM_PORTS must be within 2..8");
    end
    if (ID_WIDTH < IDX_W) begin : g_bad_id
        $error("axi_master_arbiter: ID_WIDTH too narrow for NUM_PORTS");
    end

    state_t                  state, state_n;
    logic [IDX_W-1:0]        sel, rr_ptr, arb_idx;
    logic [NUM_PORTS-1:0]    arb_grant;
    logic                    is_write;
    logic [ACCEPT_CNT_W-1:0] accept_cnt, accept_cnt_n;
    logic                    load, finish, err_set, active;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
        .req   (i_req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .index (arb_idx)
    );

    always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
        if (i_axi_rst) begin
            state      <= S_IDLE;
            accept_cnt <= '0;
        end else begin
            state      <= state_n;
            accept_cnt <= accept_cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        accept_cnt_n = accept_cnt;
        load         = 1'b0;
        finish       = 1'b0;
        err_set      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (m_ready && (|i_req_valid)) begin
                    load    = 1'b1;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                accept_cnt_n = '0;
                state_n      = S_ACCEPT;
            end
            S_ACCEPT: begin
                if (!m_ready) begin
                    state_n = S_BUSY;
                end else if (accept_cnt == ACCEPT_CNT_W'(ACCEPT_TIMEOUT - 1)) begin
                    // Master never took the strobe: flag it and release the port.
                    err_set = 1'b1;
                    finish  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    accept_cnt_n = accept_cnt + 1'b1;
                end
            end
            S_BUSY: begin
                if (m_ready) begin
                    finish  = 1'b1;
                    err_set = (m_resp_id != ID_WIDTH'(sel));
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Strobes and grant are set on the IDLE->ISSUE edge so they are high exactly in S_ISSUE.
    always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
        if (i_axi_rst) begin
            sel               <= '0;
            rr_ptr            <= '0;
            is_write          <= 1'b0;
            o_req_grant       <= '0;
            o_req_done        <= '0;
            o_id_err          <= 1'b0;
            m_start_read_stb  <= 1'b0;
            m_start_write_stb <= 1'b0;
            m_id              <= '0;
            m_addr            <= '0;
            m_data_len        <= '0;
        end else begin
            o_req_grant       <= load ? arb_grant : '0;
            m_start_read_stb  <= load & ~i_req_write[arb_idx];
            m_start_write_stb <= load &  i_req_write[arb_idx];
            o_req_done        <= finish ? (NUM_PORTS'(1) << sel) : '0;
            if (load) begin
                sel        <= arb_idx;
                is_write   <= i_req_write[arb_idx];
                m_id       <= ID_WIDTH'(arb_idx);
                m_addr     <= i_req_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                m_data_len <= i_req_len[int'(arb_idx)*8 +: 8];
            end
            // Advancing on timeout too keeps a dead master from pinning priority on one port.
            if (finish) rr_ptr <= IDX_W'(wrap_inc(int'(sel), NUM_PORTS));
            if (err_set) o_id_err <= 1'b1;
        end
    end

    assign active        = (state != S_IDLE);
    assign o_usr_r_tdata = m_r_tdata;
    assign o_usr_r_tlast = m_r_tlast;

    always_comb begin
        m_w_tdata      = '0;
        m_w_tstrb      = '0;
        m_w_tlast      = 1'b0;
        m_w_tvalid     = 1'b0;
        o_usr_w_tready = '0;
        o_usr_r_tvalid = '0;
        m_r_tready     = 1'b0;
        if (active && is_write) begin
            m_w_tdata           = i_usr_w_tdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
            m_w_tstrb           = i_usr_w_tstrb[int'(sel)*STRB_WIDTH +: STRB_WIDTH];
            m_w_tlast           = i_usr_w_tlast[sel];
            m_w_tvalid          = i_usr_w_tvalid[sel];
            o_usr_w_tready[sel] = m_w_tready;
        end
        if (active && !is_write) begin
            o_usr_r_tvalid[sel] = m_r_tvalid;
            m_r_tready          = i_usr_r_tready[sel];
        end
    end

endmodule
